// File: rtl/rcc_timer_arbiter_pkg.sv
// Shared definitions for the round-robin interval timer arbiter.
package rcc_timer_arbiter_pkg;

  localparam int CNT_W_DEF = 4;
  localparam int NREQ      = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rcc_timer_arbiter_if.sv
// Request/grant bundle between requesting control logic and the timer arbiter.
interface rcc_timer_arbiter_if
  import rcc_timer_arbiter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic [NREQ-1:0]  req;
  logic [CNT_W-1:0] len0;
  logic [CNT_W-1:0] len1;
  logic [NREQ-1:0]  gnt;
  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [NREQ-1:0]  done;

  modport master (
    output req, len0, len1,
    input  gnt, busy, cnt, done
  );

  modport slave (
    input  req, len0, len1,
    output gnt, busy, cnt, done
  );
endinterface

// File: rtl/rcc_timer_arbiter_tick_counter.sv
// Shared CNT_W-bit up-counter with synchronous clear and enable; wraps naturally.
module rcc_timer_arbiter_tick_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rcc_timer_arbiter.sv
// Round-robin arbiter granting one shared interval counter to two requesters.
module rcc_timer_arbiter
  import rcc_timer_arbiter_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PRESCALE = 1
) (
  input logic                clk,
  input logic                rst,
  rcc_timer_arbiter_if.slave bus
);

  localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  state_t           state;
  logic [PW-1:0]    presc;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt;
  logic [NREQ-1:0]  gnt_q;
  logic [NREQ-1:0]  done_q;
  logic             busy_q;
  logic             last;
  logic             cur;
  logic             win;
  logic             tick;
  logic             terminal;
  logic             abort;
  logic             clr;
  logic             en;

  assign cur      = gnt_q[1];
  assign tick     = (presc == PRE_MAX);
  assign terminal = tick && (cnt == len_q - CNT_W'(1));
  assign abort    = !bus.req[cur];

  // On a contest the requester not granted last time wins; a lone requester always wins.
  always_comb begin
    win = bus.req[1];
    if (bus.req == 2'b11) begin
      win = ~last;
    end
  end

  // The final count is held through DONE by suppressing the terminal increment.
  always_comb begin
    clr = 1'b1;
    en  = 1'b0;
    if (state == ST_RUN && !abort) begin
      clr = 1'b0;
      en  = tick && !terminal;
    end
  end

  rcc_timer_arbiter_tick_counter #(
    .CNT_W (CNT_W)
  ) u_tick_counter (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (en),
    .cnt (cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      gnt_q  <= '0;
      done_q <= '0;
      busy_q <= 1'b0;
      presc  <= '0;
      len_q  <= '0;
      last   <= 1'b1;
    end else begin
      done_q <= '0;
      case (state)
        ST_IDLE: begin
          if (|bus.req) begin
            len_q  <= win ? bus.len1 : bus.len0;
            gnt_q  <= win ? 2'b10 : 2'b01;
            presc  <= '0;
            busy_q <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            gnt_q  <= '0;
            busy_q <= 1'b0;
            last   <= cur;
            state  <= ST_IDLE;
          end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (terminal) begin
              done_q <= gnt_q;
              state  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          gnt_q  <= '0;
          busy_q <= 1'b0;
          last   <= cur;
          state  <= ST_IDLE;
        end
        default: begin
          gnt_q  <= '0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.cnt  = cnt;
  assign bus.done = done_q;

endmodule

// File: tb/tb_rcc_timer_arbiter.sv
// Directed bench for rcc_timer_arbiter with PRESCALE=1 and PRESCALE=3 instances.
module tb_rcc_timer_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rcc_timer_arbiter_if #(.CNT_W(4)) b1 ();
  rcc_timer_arbiter_if #(.CNT_W(4)) b3 ();

  rcc_timer_arbiter #(.CNT_W(4), .PRESCALE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  rcc_timer_arbiter #(.CNT_W(4), .PRESCALE(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string tag, input logic [1:0] g, input logic b,
                      input logic [3:0] c, input logic [1:0] d);
    checks++;
    assert (b1.gnt === g) else begin
      errors++; $error("FAIL %s gnt observed %b expected %b", tag, b1.gnt, g);
    end
    checks++;
    assert (b1.busy === b) else begin
      errors++; $error("FAIL %s busy observed %b expected %b", tag, b1.busy, b);
    end
    checks++;
    assert (b1.cnt === c) else begin
      errors++; $error("FAIL %s cnt observed %0d expected %0d", tag, b1.cnt, c);
    end
    checks++;
    assert (b1.done === d) else begin
      errors++; $error("FAIL %s done observed %b expected %b", tag, b1.done, d);
    end
  endtask

  task automatic chk3(input string tag, input logic [1:0] g, input logic b,
                      input logic [3:0] c, input logic [1:0] d);
    checks++;
    assert (b3.gnt === g) else begin
      errors++; $error("FAIL %s gnt observed %b expected %b", tag, b3.gnt, g);
    end
    checks++;
    assert (b3.busy === b) else begin
      errors++; $error("FAIL %s busy observed %b expected %b", tag, b3.busy, b);
    end
    checks++;
    assert (b3.cnt === c) else begin
      errors++; $error("FAIL %s cnt observed %0d expected %0d", tag, b3.cnt, c);
    end
    checks++;
    assert (b3.done === d) else begin
      errors++; $error("FAIL %s done observed %b expected %b", tag, b3.done, d);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    b1.req  = 2'b00;
    b1.len0 = 4'd0;
    b1.len1 = 4'd0;
    b3.req  = 2'b00;
    b3.len0 = 4'd0;
    b3.len1 = 4'd0;
    #1 rst = 1'b0;
    #1;
    chk1("rst1", 2'b00, 1'b0, 4'd0, 2'b00);
    chk3("rst3", 2'b00, 1'b0, 4'd0, 2'b00);

    // single request, len0=3
    @(negedge clk);
    rst     = 1'b1;
    b1.len0 = 4'd3;
    b1.req  = 2'b01;
    cyc(1); chk1("t1_c1", 2'b01, 1'b1, 4'd0, 2'b00);
    cyc(1); chk1("t1_c2", 2'b01, 1'b1, 4'd1, 2'b00);
    cyc(1); chk1("t1_c3", 2'b01, 1'b1, 4'd2, 2'b00);
    cyc(1); chk1("t1_done", 2'b01, 1'b1, 4'd2, 2'b01);
    b1.req = 2'b00;
    cyc(1); chk1("t1_idle", 2'b00, 1'b0, 4'd0, 2'b00);

    // both requesting from reset release
    rst = 1'b0;
    @(negedge clk);
    rst     = 1'b1;
    b1.len0 = 4'd2;
    b1.len1 = 4'd1;
    b1.req  = 2'b11;
    cyc(1); chk1("t2_g0", 2'b01, 1'b1, 4'd0, 2'b00);
    cyc(1); chk1("t2_c1", 2'b01, 1'b1, 4'd1, 2'b00);
    cyc(1); chk1("t2_done0", 2'b01, 1'b1, 4'd1, 2'b01);
    cyc(1); chk1("t2_idle", 2'b00, 1'b0, 4'd0, 2'b00);
    cyc(1); chk1("t2_g1", 2'b10, 1'b1, 4'd0, 2'b00);
    cyc(1); chk1("t2_done1", 2'b10, 1'b1, 4'd0, 2'b10);
    cyc(1); chk1("t2_idle2", 2'b00, 1'b0, 4'd0, 2'b00);
    cyc(1); chk1("t2_alt", 2'b01, 1'b1, 4'd0, 2'b00);
    b1.req = 2'b00;
    cyc(1); chk1("t2_abort", 2'b00, 1'b0, 4'd0, 2'b00);

    // len0=0 runs the full 16 ticks
    b1.len0 = 4'd0;
    b1.req  = 2'b01;
    for (int i = 0; i < 16; i++) begin
      cyc(1); chk1("t3_run", 2'b01, 1'b1, 4'(i), 2'b00);
    end
    cyc(1); chk1("t3_done", 2'b01, 1'b1, 4'd15, 2'b01);
    b1.req = 2'b00;
    cyc(1); chk1("t3_idle", 2'b00, 1'b0, 4'd0, 2'b00);

    // abort at cnt=2, then requester 1 is served
    b1.len0 = 4'd5;
    b1.req  = 2'b01;
    cyc(3); chk1("t4_cnt2", 2'b01, 1'b1, 4'd2, 2'b00);
    b1.req = 2'b00;
    cyc(1); chk1("t4_abort", 2'b00, 1'b0, 4'd0, 2'b00);
    b1.len1 = 4'd1;
    b1.req  = 2'b10;
    cyc(1); chk1("t4_g1", 2'b10, 1'b1, 4'd0, 2'b00);
    cyc(1); chk1("t4_done1", 2'b10, 1'b1, 4'd0, 2'b10);
    b1.req = 2'b00;
    cyc(1); chk1("t4_idle", 2'b00, 1'b0, 4'd0, 2'b00);

    // short requester 0 job so the pointer favours requester 1 before reset
    b1.len0 = 4'd1;
    b1.req  = 2'b01;
    cyc(1); chk1("t5_pre_g", 2'b01, 1'b1, 4'd0, 2'b00);
    cyc(1); chk1("t5_pre_done", 2'b01, 1'b1, 4'd0, 2'b01);
    b1.req = 2'b00;
    cyc(1); chk1("t5_pre_idle", 2'b00, 1'b0, 4'd0, 2'b00);

    // asynchronous reset mid-RUN
    b1.len0 = 4'd8;
    b1.req  = 2'b01;
    cyc(4); chk1("t5_cnt3", 2'b01, 1'b1, 4'd3, 2'b00);
    #2 rst = 1'b0;
    #1 chk1("t5_async", 2'b00, 1'b0, 4'd0, 2'b00);
    b1.req = 2'b11;
    @(negedge clk);
    rst = 1'b1;
    cyc(1); chk1("t5_rr", 2'b01, 1'b1, 4'd0, 2'b00);
    b1.req = 2'b00;
    cyc(1); chk1("t5_idle", 2'b00, 1'b0, 4'd0, 2'b00);

    // PRESCALE=3, len0=2
    b3.len0 = 4'd2;
    b3.req  = 2'b01;
    cyc(1); chk3("t6_g", 2'b01, 1'b1, 4'd0, 2'b00);
    cyc(2); chk3("t6_c3", 2'b01, 1'b1, 4'd0, 2'b00);
    cyc(1); chk3("t6_c4", 2'b01, 1'b1, 4'd1, 2'b00);
    cyc(2); chk3("t6_c6", 2'b01, 1'b1, 4'd1, 2'b00);
    cyc(1); chk3("t6_done", 2'b01, 1'b1, 4'd1, 2'b01);
    b3.req = 2'b00;
    cyc(1); chk3("t6_idle", 2'b00, 1'b0, 4'd0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rcc_timer_arbiter.md
Name: rcc_timer_arbiter

Overview:
Shares one 4-bit up-counter (ripple-carry-counter class) between two requesters. Each requester asks for a timed interval of N ticks. A round-robin arbiter grants the counter, and an FSM sequences clear, count, terminal detect and completion. It sits between requesting control logic and the shared counting resource, and provides interval timing for the surrounding design.

Parameters:
CNT_W, 4, counter width; interval lengths and cnt are CNT_W bits.
PRESCALE, 1, clk cycles per counter tick; legal range >= 1.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (rst=0 resets)
req  input  2  level request per requester; held until done or abort
len0  input  CNT_W  interval length for requester 0; sampled at grant
len1  input  CNT_W  interval length for requester 1; sampled at grant
gnt  output  2  one-hot grant; 00 when idle
busy  output  1  high whenever state != IDLE
cnt  output  CNT_W  current shared counter value
done  output  2  one-cycle completion pulse for the granted requester

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, including mid-RUN):
  - state=IDLE, gnt=00, busy=0, cnt=0, done=00.
  - Prescaler=0, latched length=0.
  - Round-robin pointer favours requester 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Req sampled at cycle t. If any bit is set, pick the winner.
  - If only one requests, it wins. If both request, the requester not most recently granted wins; requester 0 wins the first contest after reset.
  - On that edge: latch the winner's len, set gnt one-hot, clear cnt and prescaler, go to RUN.
  - gnt is visible in cycle t+1.
- RUN:
  - tick = (prescaler == PRESCALE-1). Prescaler wraps to 0 on tick and increments otherwise.
  - On tick, cnt increments by 1, modulo 2^CNT_W.
  - If tick and cnt == latched_len-1 (mod 2^CNT_W), go to DONE.
  - This gives exactly len ticks. len=0 means 2^CNT_W ticks (cnt runs 0..15 for CNT_W=4).
  - If the granted requester's req drops, abort: go to IDLE next edge, gnt=00, cnt=0, no done pulse, pointer updated as if completed.
  - The other requester's req has no effect during RUN.
- DONE:
  - Lasts exactly one cycle: done bit of the granted requester = 1, gnt held, cnt holds its final value.
  - Next edge: IDLE, gnt=00, cnt=0, pointer updated.
  - Earliest re-grant is the cycle after the IDLE cycle. Each grant costs one IDLE arbitration cycle.
- Latency:
  - With PRESCALE=1, req at t gives done at t+L+1 (L=len, 0 treated as 2^CNT_W).
  - In general, done arrives at t+1+L*PRESCALE.
- Arithmetic: cnt and len compare are CNT_W wide, unsigned, wrap naturally. No saturation.
- Outputs are registered; no combinational path from req/len to any output.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, RUN, DONE).
  - Default CNT_W=4.
  - Requester count constant NREQ=2.
- One sub-module: tick_counter.
  - CNT_W-bit up-counter with synchronous clear, enable and wrap.
  - Same clk and active-low async rst.
- Arbiter, prescaler and FSM remain in rcc_timer_arbiter.

Test Plan:
1. PRESCALE=1, req0=1 at cycle 0, len0=3 -> gnt=01 at cycles 1-4; cnt=0,1,2 at cycles 1-3, holds 2 at cycle 4; done=01 at cycle 4 only; gnt=00, cnt=0, busy=0 at cycle 5.
2. Both req high from reset release, len0=2, len1=1 -> requester 0 first (done=01 at cycle 3); IDLE at cycle 4; gnt=10 at cycle 5; done=10 at cycle 6; grants then alternate while both stay high.
3. len0=0, PRESCALE=1 -> cnt counts 0..15 over 16 cycles; done=01 17 cycles after req; cnt=0 afterwards.
4. req0 drops when cnt=2 (len0=5) -> next cycle gnt=00, busy=0, cnt=0, done never asserted; a subsequent req1 is granted.
5. rst driven low between clock edges while RUN at cnt=3 -> gnt, cnt, busy, done go to 0 immediately without a clock edge; after release, a simultaneous req grants requester 0.
6. PRESCALE=3, len0=2, req0 at cycle 0 -> gnt at cycle 1; cnt becomes 1 at cycle 4; done=01 at cycle 7.
